// File: rtl/mem_model_pkg.sv
// mem_model shared types: FSM states, trigger modes, latency helpers.
// Optional feature macro: MEM_MODEL_ERR_EN (out-of-range error pulse).
package mem_model_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int TRIG_STROBE = 0;
    localparam int TRIG_ADDR   = 1;

    // Latency of an access: write or read.
    function automatic int lat_sel(
        input logic wr,
        input int   rd_lat,
        input int   wr_lat
    );
        return wr ? wr_lat : rd_lat;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_model_if.sv
// mem_model bus: core-side request fields plus ready/read data.
// Carries err only when MEM_MODEL_ERR_EN is defined.
interface mem_model_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req;
    logic              memory_w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              memory_ready;
`ifdef MEM_MODEL_ERR_EN
    logic              err;

    modport master (
        output req, memory_w, addr, wdata,
        input  rdata, memory_ready, err
    );

    modport slave (
        input  req, memory_w, addr, wdata,
        output rdata, memory_ready, err
    );
`else
    modport master (
        output req, memory_w, addr, wdata,
        input  rdata, memory_ready
    );

    modport slave (
        input  req, memory_w, addr, wdata,
        output rdata, memory_ready
    );
`endif
endinterface

// File: rtl/mem_model_array.sv
// Single-port synchronous RAM with registered read data.
// Read register has a synchronous clear so rdata can be forced to 0.
module mem_model_array #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 1024,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rdata_q;

    // Storage write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Registered read port; clear wins over a read.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_model.sv
// Cycle-accurate memory latency model with real storage.
// Macro MEM_MODEL_ERR_EN: out-of-range accesses are dropped and pulse err.
module mem_model
    import mem_model_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 1024,
    parameter int RD_LAT    = 1,
    parameter int WR_LAT    = 2,
    parameter int TRIG_MODE = 0
) (
    input logic       clk,
    input logic       rst,
    mem_model_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(max2(RD_LAT, WR_LAT) + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] old_addr_q, old_addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              trig;
    logic              done;
    logic              oor;
    logic              ram_we, ram_re, ram_clr;
`ifdef MEM_MODEL_ERR_EN
    logic              oor_q, oor_d;
    logic              err_q, err_d;

    assign oor      = oor_q;
    assign bus.err  = err_q;
`else
    assign oor      = 1'b0;
`endif

    assign trig = (TRIG_MODE == TRIG_ADDR) ? (bus.addr != old_addr_q)
                                           : bus.req;

    // Accept in IDLE, count down in BUSY, complete when counter hits 0.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        old_addr_d = old_addr_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        ready_d    = ready_q;
        done       = 1'b0;
`ifdef MEM_MODEL_ERR_EN
        oor_d      = oor_q;
        err_d      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d    = BUSY;
                    cnt_d      = CNT_W'(lat_sel(bus.memory_w,
                                                RD_LAT, WR_LAT) - 1);
                    old_addr_d = bus.addr;
                    idx_d      = bus.addr[IDX_W-1:0];
                    wr_d       = bus.memory_w;
                    wdata_d    = bus.wdata;
                    ready_d    = 1'b0;
`ifdef MEM_MODEL_ERR_EN
                    oor_d      = |(bus.addr >> IDX_W);
`endif
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    ready_d = 1'b1;
`ifdef MEM_MODEL_ERR_EN
                    err_d   = oor_q;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request latches; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            old_addr_q <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            ready_q    <= 1'b1;
`ifdef MEM_MODEL_ERR_EN
            oor_q      <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            old_addr_q <= old_addr_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
`ifdef MEM_MODEL_ERR_EN
            oor_q      <= oor_d;
            err_q      <= err_d;
`endif
        end
    end

    assign ram_we  = done & wr_q & ~oor & ~rst;
    assign ram_re  = done & ~wr_q & ~oor & ~rst;
    assign ram_clr = rst | (done & ~wr_q & oor);

    mem_model_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .clr_i   (ram_clr),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (bus.rdata)
    );

    assign bus.memory_ready = ready_q;

endmodule

// File: tb/tb_mem_model.sv
// Directed plus randomized bench for mem_model on three configurations.
// Expectations come from a flat array model of the storage and latencies.
module tb_mem_model;

    localparam int DEPTH = 1024;
    localparam int RDL [3] = '{1, 3, 2};
    localparam int WRL [3] = '{2, 2, 4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_s [3];
    logic        w_s   [3];
    logic [15:0] a_s   [3];
    logic [15:0] d_s   [3];
    logic [2:0]  rdy_s;
    logic [15:0] rd_s  [3];

    mem_model_if #(.DATA_W(16), .ADDR_W(16)) b0 ();
    mem_model_if #(.DATA_W(16), .ADDR_W(16)) b1 ();
    mem_model_if #(.DATA_W(16), .ADDR_W(16)) b2 ();

    assign b0.req = req_s[0];
    assign b1.req = req_s[1];
    assign b2.req = req_s[2];
    assign b0.memory_w = w_s[0];
    assign b1.memory_w = w_s[1];
    assign b2.memory_w = w_s[2];
    assign b0.addr = a_s[0];
    assign b1.addr = a_s[1];
    assign b2.addr = a_s[2];
    assign b0.wdata = d_s[0];
    assign b1.wdata = d_s[1];
    assign b2.wdata = d_s[2];
    assign rdy_s[0] = b0.memory_ready;
    assign rdy_s[1] = b1.memory_ready;
    assign rdy_s[2] = b2.memory_ready;
    assign rd_s[0] = b0.rdata;
    assign rd_s[1] = b1.rdata;
    assign rd_s[2] = b2.rdata;
`ifdef MEM_MODEL_ERR_EN
    logic [2:0] err_s;
    assign err_s[0] = b0.err;
    assign err_s[1] = b1.err;
    assign err_s[2] = b2.err;
`endif

    mem_model #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH),
        .RD_LAT(1), .WR_LAT(2), .TRIG_MODE(0)
    ) u_dut0 (.clk(clk), .rst(rst), .bus(b0));

    mem_model #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH),
        .RD_LAT(3), .WR_LAT(2), .TRIG_MODE(1)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

    mem_model #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH),
        .RD_LAT(2), .WR_LAT(4), .TRIG_MODE(0)
    ) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_m [3][DEPTH];
    logic [15:0] exp_rd [3];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic out_of_range(input logic [15:0] a);
`ifdef MEM_MODEL_ERR_EN
        return a >= 16'(DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    // Count samples with ready low; rdata must hold, err must stay low.
    task automatic wait_hi(input int k, input logic [15:0] hold,
                           output int n);
        n = 0;
        while (rdy_s[k] !== 1'b1 && n < 20) begin
            n++;
            chk("busy_rdata_hold", 32'(rd_s[k]), 32'(hold));
`ifdef MEM_MODEL_ERR_EN
            chk("busy_err_low", 32'(err_s[k]), 32'd0);
`endif
            tick();
        end
    endtask

    // Apply the model's effect of a completed access and check outputs.
    task automatic complete(input int k, input logic w,
                            input logic [15:0] a, input logic [15:0] d);
        int   idx;
        logic oor;
        idx = int'(a) % DEPTH;
        oor = out_of_range(a);
        if (w) begin
            if (!oor) mem_m[k][idx] = d;
        end else begin
            exp_rd[k] = oor ? 16'h0 : mem_m[k][idx];
        end
        chk("done_rdata", 32'(rd_s[k]), 32'(exp_rd[k]));
`ifdef MEM_MODEL_ERR_EN
        chk("done_err", 32'(err_s[k]), 32'(oor));
`endif
    endtask

    // One access: strobe for modes 0, address change for dut 1.
    task automatic access(input int k, input logic w,
                          input logic [15:0] a, input logic [15:0] d);
        int n;
        w_s[k] = w;
        a_s[k] = a;
        d_s[k] = d;
        if (k != 1) req_s[k] = 1'b1;
        tick();
        req_s[k] = 1'b0;
        wait_hi(k, exp_rd[k], n);
        chk(w ? "wr_busy_len" : "rd_busy_len", 32'(n),
            32'(w ? WRL[k] : RDL[k]));
        complete(k, w, a, d);
    endtask

    // req held high: ready must follow a period of L+1 with no extra accept.
    task automatic busy_drop(input int k, input logic [15:0] a);
        int   per;
        logic hi;
        per = RDL[k] + 1;
        w_s[k] = 1'b0;
        a_s[k] = a;
        req_s[k] = 1'b1;
        for (int n = 0; n < 3 * per; n++) begin
            tick();
            hi = (n % per) == (per - 1);
            chk("drop_ready", 32'(rdy_s[k]), 32'(hi));
            if (hi) begin
                exp_rd[k] = mem_m[k][int'(a) % DEPTH];
                chk("drop_rdata", 32'(rd_s[k]), 32'(exp_rd[k]));
            end
        end
        req_s[k] = 1'b0;
        tick();
        chk("drop_idle", 32'(rdy_s[k]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        logic        w;
        logic [15:0] a, d, prev;

        for (int k = 0; k < 3; k++) begin
            req_s[k] = 1'b0;
            w_s[k]   = 1'b0;
            a_s[k]   = 16'h0;
            d_s[k]   = 16'h0;
            exp_rd[k] = 16'h0;
            for (int i = 0; i < DEPTH; i++) mem_m[k][i] = 16'h0;
        end

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("reset_ready", 32'(rdy_s[k]), 32'd1);
            chk("reset_rdata", 32'(rd_s[k]), 32'd0);
`ifdef MEM_MODEL_ERR_EN
            chk("reset_err", 32'(err_s[k]), 32'd0);
`endif
        end

        access(0, 1'b1, 16'd5, 16'hBEEF);
        access(0, 1'b0, 16'd5, 16'h0);
        chk("strobe_read_beef", 32'(rd_s[0]), 32'h0000BEEF);

        access(2, 1'b1, 16'd3, 16'h1111);
        w_s[2] = 1'b1;
        a_s[2] = 16'd3;
        d_s[2] = 16'h2222;
        req_s[2] = 1'b1;
        tick();
        req_s[2] = 1'b0;
        chk("midwr_busy1", 32'(rdy_s[2]), 32'd0);
        tick();
        chk("midwr_busy2", 32'(rdy_s[2]), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_rd[k] = 16'h0;
            chk("midwr_rst_ready", 32'(rdy_s[k]), 32'd1);
            chk("midwr_rst_rdata", 32'(rd_s[k]), 32'd0);
        end
        access(2, 1'b0, 16'd3, 16'h0);
        chk("midwr_old_value", 32'(rd_s[2]), 32'h00001111);

        access(1, 1'b1, 16'd9, 16'h5A5A);
        access(1, 1'b0, 16'd0, 16'h0);
        w_s[1] = 1'b0;
        a_s[1] = 16'd7;
        tick();
        a_s[1] = 16'd9;
        wait_hi(1, exp_rd[1], n);
        chk("legacy_len_7", 32'(n), 32'd3);
        exp_rd[1] = mem_m[1][7];
        chk("legacy_rdata_7", 32'(rd_s[1]), 32'(exp_rd[1]));
        prev = exp_rd[1];
        tick();
        wait_hi(1, prev, n);
        chk("legacy_len_9", 32'(n), 32'd3);
        exp_rd[1] = mem_m[1][9];
        chk("legacy_rdata_9", 32'(rd_s[1]), 32'h00005A5A);
        tick();
        chk("legacy_settled", 32'(rdy_s[1]), 32'd1);

        busy_drop(0, 16'd5);
        busy_drop(2, 16'd3);

        access(0, 1'b1, 16'h0405, 16'h1234);
        access(0, 1'b0, 16'h0005, 16'h0);
`ifdef MEM_MODEL_ERR_EN
        chk("err_alias_kept", 32'(rd_s[0]), 32'h0000BEEF);
`else
        chk("alias_landed", 32'(rd_s[0]), 32'h00001234);
`endif

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 3; k += 2) begin
                w = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) a = 16'($urandom);
                else a = 16'($urandom_range(0, 15));
                d = 16'($urandom);
                access(k, w, a, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
